// File: rtl/multicycle_control_unit.sv
// Control FSM for the RV32I multicycle datapath: fetch, decode, execute, memory, writeback.
// Optional build macro ILLEGAL_TRAP_EN: illegal instructions park the FSM in TRAP and raise illegal_instr.
module multicycle_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        zero,
    input  logic        mem_op_r,
    output logic        pc_enable,
    output logic        old_pc_enable,
    output logic        ir_reg_enable,
    output logic        mem_reg_enable,
    output logic        alu_reg_enable,
    output logic        mem_enable,
    output logic        mem_write_enable,
    output logic        memsel_mux_select,
    output logic        alu_reg_mux_select,
    output logic        rf_we,
    output logic [1:0]  regfile_mux_select,
    output logic [1:0]  opsel1_select,
    output logic [1:0]  opsel2_select,
    output logic [3:0]  alu_sel,
    output logic [3:0]  imm_src,
    output logic [1:0]  instr_mode,
    output logic [4:0]  state,
    output logic        illegal_instr
);

    typedef enum logic [4:0] {
        FETCH     = 5'd0,
        DECODE    = 5'd1,
        EXEC_R    = 5'd2,
        EXEC_I    = 5'd3,
        ALU_WB    = 5'd4,
        MEM_ADDR  = 5'd5,
        LOAD      = 5'd6,
        LOAD_WB   = 5'd7,
        STORE     = 5'd8,
        BRANCH    = 5'd9,
        JAL_LINK  = 5'd10,
        JAL_TGT   = 5'd11,
        JALR_ADDR = 5'd12,
        JALR_JUMP = 5'd13,
        JALR_LINK = 5'd14,
        LUI       = 5'd15,
        AUIPC     = 5'd16,
        ILLEGAL   = 5'd17,
        TRAP      = 5'd18
    } state_t;

    localparam logic [3:0] IMM_I   = 4'b0000;
    localparam logic [3:0] IMM_S   = 4'b0001;
    localparam logic [3:0] IMM_B   = 4'b0010;
    localparam logic [3:0] IMM_U   = 4'b0011;
    localparam logic [3:0] IMM_J   = 4'b0100;
    localparam logic [3:0] IMM_LB  = 4'b0101;
    localparam logic [3:0] IMM_LH  = 4'b0110;
    localparam logic [3:0] IMM_LBU = 4'b0111;
    localparam logic [3:0] IMM_LHU = 4'b1000;
    localparam logic [3:0] IMM_LW  = 4'b1001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;

    state_t      cur, nxt;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [1:0]  mem_mode;
    logic        br_taken;
    logic        unused_ir_bits;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    assign mem_mode = (f3[1:0] == 2'b00) ? 2'b10 :
                      (f3[1:0] == 2'b01) ? 2'b01 : 2'b00;

    // SUB feeds zero for EQ/NE; SLT/SLTU leave zero=1 when the "less" test fails.
    assign br_taken = f3[2] ? ~(zero ^ f3[0]) : (zero ^ f3[0]);

    assign state = reset ? 5'd0 : cur;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = !reset && (cur == TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt                = cur;
        pc_enable          = 1'b0;
        old_pc_enable      = 1'b0;
        ir_reg_enable      = 1'b0;
        mem_reg_enable     = 1'b0;
        alu_reg_enable     = 1'b0;
        mem_enable         = 1'b0;
        mem_write_enable   = 1'b0;
        memsel_mux_select  = 1'b0;
        alu_reg_mux_select = 1'b0;
        rf_we              = 1'b0;
        regfile_mux_select = 2'b00;
        opsel1_select      = 2'b00;
        opsel2_select      = 2'b00;
        alu_sel            = ALU_ADD;
        imm_src            = IMM_I;
        instr_mode         = 2'b00;
        if (!reset) begin
            case (cur)
                FETCH: begin
                    mem_enable = 1'b1;
                    if (mem_op_r) begin
                        ir_reg_enable      = 1'b1;
                        old_pc_enable      = 1'b1;
                        pc_enable          = 1'b1;
                        opsel1_select      = 2'b01;
                        opsel2_select      = 2'b01;
                        alu_reg_mux_select = 1'b1;
                        nxt                = DECODE;
                    end
                end
                DECODE: begin
                    opsel1_select  = 2'b10;
                    imm_src        = IMM_B;
                    alu_reg_enable = 1'b1;
                    case (opcode)
                        7'b0110011:             nxt = EXEC_R;
                        7'b0010011:             nxt = EXEC_I;
                        7'b0000011, 7'b0100011: nxt = MEM_ADDR;
                        7'b1100011:             nxt = (f3[2:1] == 2'b01) ? ILLEGAL : BRANCH;
                        7'b1101111:             nxt = JAL_LINK;
                        7'b1100111:             nxt = JALR_ADDR;
                        7'b0110111:             nxt = LUI;
                        7'b0010111:             nxt = AUIPC;
                        default:                nxt = ILLEGAL;
                    endcase
                end
                EXEC_R: begin
                    opsel2_select  = 2'b10;
                    alu_sel        = {ir[30], f3};
                    alu_reg_enable = 1'b1;
                    nxt            = ALU_WB;
                end
                EXEC_I: begin
                    alu_sel        = {(f3 == 3'b101) & ir[30], f3};
                    alu_reg_enable = 1'b1;
                    nxt            = ALU_WB;
                end
                ALU_WB: begin
                    regfile_mux_select = 2'b01;
                    rf_we              = 1'b1;
                    nxt                = FETCH;
                end
                MEM_ADDR: begin
                    imm_src        = opcode[5] ? IMM_S : IMM_I;
                    alu_reg_enable = 1'b1;
                    nxt            = opcode[5] ? STORE : LOAD;
                end
                LOAD: begin
                    memsel_mux_select = 1'b1;
                    mem_enable        = 1'b1;
                    instr_mode        = mem_mode;
                    if (mem_op_r) begin
                        mem_reg_enable = 1'b1;
                        nxt            = LOAD_WB;
                    end
                end
                LOAD_WB: begin
                    regfile_mux_select = 2'b10;
                    rf_we              = 1'b1;
                    case (f3)
                        3'b000:  imm_src = IMM_LB;
                        3'b001:  imm_src = IMM_LH;
                        3'b100:  imm_src = IMM_LBU;
                        3'b101:  imm_src = IMM_LHU;
                        default: imm_src = IMM_LW;
                    endcase
                    nxt = FETCH;
                end
                STORE: begin
                    memsel_mux_select = 1'b1;
                    mem_enable        = 1'b1;
                    mem_write_enable  = 1'b1;
                    instr_mode        = mem_mode;
                    if (mem_op_r) nxt = FETCH;
                end
                BRANCH: begin
                    opsel2_select = 2'b10;
                    alu_sel       = f3[2] ? {3'b001, f3[1]} : ALU_SUB;
                    pc_enable     = br_taken;
                    nxt           = FETCH;
                end
                JAL_LINK, JALR_LINK: begin
                    opsel1_select      = 2'b10;
                    opsel2_select      = 2'b01;
                    alu_reg_mux_select = 1'b1;
                    regfile_mux_select = 2'b01;
                    rf_we              = 1'b1;
                    nxt                = (cur == JAL_LINK) ? JAL_TGT : FETCH;
                end
                JAL_TGT: begin
                    opsel1_select      = 2'b10;
                    imm_src            = IMM_J;
                    alu_reg_mux_select = 1'b1;
                    pc_enable          = 1'b1;
                    nxt                = FETCH;
                end
                JALR_ADDR: begin
                    alu_reg_enable = 1'b1;
                    nxt            = JALR_JUMP;
                end
                JALR_JUMP: begin
                    pc_enable = 1'b1;
                    nxt       = JALR_LINK;
                end
                LUI: begin
                    imm_src            = IMM_U;
                    regfile_mux_select = 2'b10;
                    rf_we              = 1'b1;
                    nxt                = FETCH;
                end
                AUIPC: begin
                    opsel1_select      = 2'b10;
                    imm_src            = IMM_U;
                    alu_reg_mux_select = 1'b1;
                    regfile_mux_select = 2'b01;
                    rf_we              = 1'b1;
                    nxt                = FETCH;
                end
                ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                    nxt = TRAP;
`else
                    nxt = FETCH;
`endif
                end
                TRAP:    nxt = TRAP;
                default: nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit: each cycle drives ir/zero/mem_op_r/reset and checks every output.
// Honours ILLEGAL_TRAP_EN to pick the expected illegal-instruction behaviour.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        zero;
    logic        mem_op_r;
    logic        pc_enable, old_pc_enable, ir_reg_enable, mem_reg_enable, alu_reg_enable;
    logic        mem_enable, mem_write_enable, memsel_mux_select, alu_reg_mux_select, rf_we;
    logic [1:0]  regfile_mux_select, opsel1_select, opsel2_select, instr_mode;
    logic [3:0]  alu_sel, imm_src;
    logic [4:0]  state;
    logic        illegal_instr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk                (clk),
        .reset              (reset),
        .ir                 (ir),
        .zero               (zero),
        .mem_op_r           (mem_op_r),
        .pc_enable          (pc_enable),
        .old_pc_enable      (old_pc_enable),
        .ir_reg_enable      (ir_reg_enable),
        .mem_reg_enable     (mem_reg_enable),
        .alu_reg_enable     (alu_reg_enable),
        .mem_enable         (mem_enable),
        .mem_write_enable   (mem_write_enable),
        .memsel_mux_select  (memsel_mux_select),
        .alu_reg_mux_select (alu_reg_mux_select),
        .rf_we              (rf_we),
        .regfile_mux_select (regfile_mux_select),
        .opsel1_select      (opsel1_select),
        .opsel2_select      (opsel2_select),
        .alu_sel            (alu_sel),
        .imm_src            (imm_src),
        .instr_mode         (instr_mode),
        .state              (state),
        .illegal_instr      (illegal_instr)
    );

    typedef struct packed {
        logic       pce, opce, ire, mre, are, me, mwe, msel, armux, rfwe;
        logic [1:0] rfmux, op1, op2;
        logic [3:0] alu, imm;
        logic [1:0] mode;
        logic [4:0] st;
        logic       ill;
    } ctl_t;

    ctl_t obs;
    assign obs = {pc_enable, old_pc_enable, ir_reg_enable, mem_reg_enable, alu_reg_enable,
                  mem_enable, mem_write_enable, memsel_mux_select, alu_reg_mux_select, rf_we,
                  regfile_mux_select, opsel1_select, opsel2_select, alu_sel, imm_src,
                  instr_mode, state, illegal_instr};

    localparam logic [4:0] S_FETCH = 5'd0,  S_DECODE = 5'd1,  S_EXEC_R = 5'd2,  S_EXEC_I = 5'd3,
                           S_ALU_WB = 5'd4, S_MEM_ADDR = 5'd5, S_LOAD = 5'd6,   S_LOAD_WB = 5'd7,
                           S_STORE = 5'd8,  S_BRANCH = 5'd9,  S_JAL_LINK = 5'd10, S_JAL_TGT = 5'd11,
                           S_JALR_ADDR = 5'd12, S_JALR_JUMP = 5'd13, S_JALR_LINK = 5'd14,
                           S_LUI = 5'd15, S_AUIPC = 5'd16, S_ILLEGAL = 5'd17, S_TRAP = 5'd18;

    localparam ctl_t ZERO_OUT = '{default: '0};
    localparam ctl_t F_WAIT   = '{me: 1'b1, st: S_FETCH, default: '0};
    localparam ctl_t F_DONE   = '{me: 1'b1, ire: 1'b1, opce: 1'b1, pce: 1'b1, op1: 2'd1, op2: 2'd1,
                                  armux: 1'b1, st: S_FETCH, default: '0};
    localparam ctl_t DEC      = '{op1: 2'd2, imm: 4'd2, are: 1'b1, st: S_DECODE, default: '0};
    localparam ctl_t ALU_WB   = '{rfmux: 2'd1, rfwe: 1'b1, st: S_ALU_WB, default: '0};

    typedef struct {
        logic        rst;
        logic [31:0] ir;
        logic        zero;
        logic        mop;
        ctl_t        e;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic [31:0] i, input logic z,
                                input logic m, input ctl_t e);
        vec_t v;
        v.rst = r; v.ir = i; v.zero = z; v.mop = m; v.e = e;
        vq.push_back(v);
    endfunction

    task automatic test_reset();
        vq.delete();
        add(1'b1, 32'h0080A103, 1'b1, 1'b1, ZERO_OUT);
        add(1'b1, 32'h0000006F, 1'b0, 1'b1, ZERO_OUT);
        foreach (vq[i]) begin
            reset = vq[i].rst; ir = vq[i].ir; zero = vq[i].zero; mem_op_r = vq[i].mop;
            #1; n_cmp++;
            if (obs !== vq[i].e) begin
                $display("FAIL reset[%0d] got %h want %h", i, obs, vq[i].e); n_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fetch_addi();
        vq.delete();
        add(1'b0, 32'h00500093, 1'b0, 1'b0, F_WAIT);
        add(1'b0, 32'h00500093, 1'b0, 1'b0, F_WAIT);
        add(1'b0, 32'h00500093, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h00500093, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h00500093, 1'b0, 1'b0, '{are: 1'b1, st: S_EXEC_I, default: '0});
        add(1'b0, 32'h00500093, 1'b0, 1'b0, ALU_WB);
        add(1'b0, 32'h00500093, 1'b0, 1'b0, F_WAIT);
        foreach (vq[i]) begin
            reset = vq[i].rst; ir = vq[i].ir; zero = vq[i].zero; mem_op_r = vq[i].mop;
            #1; n_cmp++;
            if (obs !== vq[i].e) begin
                $display("FAIL fetch_addi[%0d] got %h want %h", i, obs, vq[i].e); n_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_ops();
        vq.delete();
        // SUB x3,x1,x2
        add(1'b0, 32'h402081B3, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h402081B3, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h402081B3, 1'b0, 1'b0, '{op2: 2'd2, alu: 4'd8, are: 1'b1, st: S_EXEC_R, default: '0});
        add(1'b0, 32'h402081B3, 1'b0, 1'b0, ALU_WB);
        // SRAI x1,x1,3 keeps ir[30]
        add(1'b0, 32'h4030D093, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h4030D093, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h4030D093, 1'b0, 1'b0, '{alu: 4'd13, are: 1'b1, st: S_EXEC_I, default: '0});
        add(1'b0, 32'h4030D093, 1'b0, 1'b0, ALU_WB);
        // ADDI x1,x0,-1024 has ir[30]=1 but must stay ADD
        add(1'b0, 32'hC0000093, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'hC0000093, 1'b0, 1'b0, DEC);
        add(1'b0, 32'hC0000093, 1'b0, 1'b0, '{are: 1'b1, st: S_EXEC_I, default: '0});
        add(1'b0, 32'hC0000093, 1'b0, 1'b0, ALU_WB);
        add(1'b0, 32'hC0000093, 1'b0, 1'b0, F_WAIT);
        foreach (vq[i]) begin
            reset = vq[i].rst; ir = vq[i].ir; zero = vq[i].zero; mem_op_r = vq[i].mop;
            #1; n_cmp++;
            if (obs !== vq[i].e) begin
                $display("FAIL alu_ops[%0d] got %h want %h", i, obs, vq[i].e); n_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_store();
        ctl_t ld, st;
        ld = '{msel: 1'b1, me: 1'b1, mode: 2'd0, st: S_LOAD, default: '0};
        st = '{msel: 1'b1, me: 1'b1, mwe: 1'b1, mode: 2'd1, st: S_STORE, default: '0};
        vq.delete();
        // LW x2,8(x1), memory answers after 3 wait cycles
        add(1'b0, 32'h0080A103, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, '{are: 1'b1, st: S_MEM_ADDR, default: '0});
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, ld);
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, ld);
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, ld);
        ld.mre = 1'b1;
        add(1'b0, 32'h0080A103, 1'b0, 1'b1, ld);
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, '{rfmux: 2'd2, imm: 4'd9, rfwe: 1'b1, st: S_LOAD_WB, default: '0});
        // SH x2,4(x1), strobe held through the wait
        add(1'b0, 32'h00209223, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h00209223, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h00209223, 1'b0, 1'b0, '{are: 1'b1, imm: 4'd1, st: S_MEM_ADDR, default: '0});
        add(1'b0, 32'h00209223, 1'b0, 1'b0, st);
        add(1'b0, 32'h00209223, 1'b0, 1'b0, st);
        add(1'b0, 32'h00209223, 1'b0, 1'b1, st);
        add(1'b0, 32'h00209223, 1'b0, 1'b0, F_WAIT);
        foreach (vq[i]) begin
            reset = vq[i].rst; ir = vq[i].ir; zero = vq[i].zero; mem_op_r = vq[i].mop;
            #1; n_cmp++;
            if (obs !== vq[i].e) begin
                $display("FAIL load_store[%0d] got %h want %h", i, obs, vq[i].e); n_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        vq.delete();
        // BEQ zero=1 taken, BNE zero=1 not taken, BGE zero=0 not taken, BLTU zero=0 taken
        add(1'b0, 32'h00000063, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h00000063, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h00000063, 1'b1, 1'b0, '{op2: 2'd2, alu: 4'd8, pce: 1'b1, st: S_BRANCH, default: '0});
        add(1'b0, 32'h00001063, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h00001063, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h00001063, 1'b1, 1'b0, '{op2: 2'd2, alu: 4'd8, st: S_BRANCH, default: '0});
        add(1'b0, 32'h00005063, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h00005063, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h00005063, 1'b0, 1'b0, '{op2: 2'd2, alu: 4'd2, st: S_BRANCH, default: '0});
        add(1'b0, 32'h00006063, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h00006063, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h00006063, 1'b0, 1'b0, '{op2: 2'd2, alu: 4'd3, pce: 1'b1, st: S_BRANCH, default: '0});
        add(1'b0, 32'h00006063, 1'b0, 1'b0, F_WAIT);
        foreach (vq[i]) begin
            reset = vq[i].rst; ir = vq[i].ir; zero = vq[i].zero; mem_op_r = vq[i].mop;
            #1; n_cmp++;
            if (obs !== vq[i].e) begin
                $display("FAIL branch[%0d] got %h want %h", i, obs, vq[i].e); n_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jumps();
        ctl_t link;
        link = '{op1: 2'd2, op2: 2'd1, armux: 1'b1, rfmux: 2'd1, rfwe: 1'b1, st: S_JAL_LINK, default: '0};
        vq.delete();
        // JAL x0,0
        add(1'b0, 32'h0000006F, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h0000006F, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h0000006F, 1'b0, 1'b0, link);
        add(1'b0, 32'h0000006F, 1'b0, 1'b0, '{op1: 2'd2, imm: 4'd4, armux: 1'b1, pce: 1'b1, st: S_JAL_TGT, default: '0});
        // JALR x1,0(x1)
        link.st = S_JALR_LINK;
        add(1'b0, 32'h000080E7, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h000080E7, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h000080E7, 1'b0, 1'b0, '{are: 1'b1, st: S_JALR_ADDR, default: '0});
        add(1'b0, 32'h000080E7, 1'b0, 1'b0, '{pce: 1'b1, st: S_JALR_JUMP, default: '0});
        add(1'b0, 32'h000080E7, 1'b0, 1'b0, link);
        add(1'b0, 32'h000080E7, 1'b0, 1'b0, F_WAIT);
        foreach (vq[i]) begin
            reset = vq[i].rst; ir = vq[i].ir; zero = vq[i].zero; mem_op_r = vq[i].mop;
            #1; n_cmp++;
            if (obs !== vq[i].e) begin
                $display("FAIL jumps[%0d] got %h want %h", i, obs, vq[i].e); n_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_upper_imm();
        vq.delete();
        add(1'b0, 32'h000010B7, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h000010B7, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h000010B7, 1'b0, 1'b0, '{imm: 4'd3, rfmux: 2'd2, rfwe: 1'b1, st: S_LUI, default: '0});
        add(1'b0, 32'h00001097, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h00001097, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h00001097, 1'b0, 1'b0, '{op1: 2'd2, imm: 4'd3, armux: 1'b1, rfmux: 2'd1, rfwe: 1'b1,
                                             st: S_AUIPC, default: '0});
        add(1'b0, 32'h00001097, 1'b0, 1'b0, F_WAIT);
        foreach (vq[i]) begin
            reset = vq[i].rst; ir = vq[i].ir; zero = vq[i].zero; mem_op_r = vq[i].mop;
            #1; n_cmp++;
            if (obs !== vq[i].e) begin
                $display("FAIL upper_imm[%0d] got %h want %h", i, obs, vq[i].e); n_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wait();
        vq.delete();
        add(1'b0, 32'h0080A103, 1'b0, 1'b1, F_DONE);
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, DEC);
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, '{are: 1'b1, st: S_MEM_ADDR, default: '0});
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, '{msel: 1'b1, me: 1'b1, st: S_LOAD, default: '0});
        add(1'b1, 32'h0080A103, 1'b0, 1'b1, ZERO_OUT);
        add(1'b0, 32'h0080A103, 1'b0, 1'b0, F_WAIT);
        foreach (vq[i]) begin
            reset = vq[i].rst; ir = vq[i].ir; zero = vq[i].zero; mem_op_r = vq[i].mop;
            #1; n_cmp++;
            if (obs !== vq[i].e) begin
                $display("FAIL reset_mid_wait[%0d] got %h want %h", i, obs, vq[i].e); n_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = 32'h0000007F;
        bad[1] = 32'h00002063;
        vq.delete();
        for (int unsigned k = 0; k < 2; k++) begin
            add(1'b0, bad[k], 1'b0, 1'b1, F_DONE);
            add(1'b0, bad[k], 1'b0, 1'b0, DEC);
            add(1'b0, bad[k], 1'b0, 1'b0, '{st: S_ILLEGAL, default: '0});
`ifdef ILLEGAL_TRAP_EN
            add(1'b0, bad[k], 1'b0, 1'b1, '{st: S_TRAP, ill: 1'b1, default: '0});
            add(1'b0, 32'h00500093, 1'b1, 1'b1, '{st: S_TRAP, ill: 1'b1, default: '0});
            add(1'b0, 32'h00500093, 1'b0, 1'b0, '{st: S_TRAP, ill: 1'b1, default: '0});
            add(1'b1, 32'h00500093, 1'b0, 1'b0, ZERO_OUT);
`endif
            add(1'b0, bad[k], 1'b0, 1'b0, F_WAIT);
        end
        foreach (vq[i]) begin
            reset = vq[i].rst; ir = vq[i].ir; zero = vq[i].zero; mem_op_r = vq[i].mop;
            #1; n_cmp++;
            if (obs !== vq[i].e) begin
                $display("FAIL illegal[%0d] got %h want %h", i, obs, vq[i].e); n_err++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; ir = '0; zero = 1'b0; mem_op_r = 1'b0;
        @(negedge clk);
        test_reset();
        test_fetch_addi();
        test_alu_ops();
        test_load_store();
        test_branch();
        test_jumps();
        test_upper_imm();
        test_reset_mid_wait();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
